// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if
//   Bundles the two requester ports (IF fetch, D load/store), the Memory pins
//   and the busy flag of mem_access_arbiter.
//   slave  : arbiter side (drives done/rdata/err, mem_* strobes, busy)
//   master : surroundings side (requesters plus the Memory instance)
// Signals
//   if_req/if_addr          fetch request and byte address
//   if_done/if_rdata/if_err fetch response, valid for the single cycle if_done=1
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store, 0 load)
//   d_done/d_rdata/d_err    data response, valid for the single cycle d_done=1
//   mem_addr/mem_read/mem_write/mem_wdata  to Memory
//   mem_rdata               from Memory (combinational read word)
//   busy                    arbiter is not idle
interface mem_access_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, if_err, d_done, d_rdata, d_err,
           mem_addr, mem_read, mem_write, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, if_err, d_done, d_rdata, d_err,
           mem_addr, mem_read, mem_write, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares a single-port, byte-addressed, big-endian Memory between the
//   instruction fetch (IF) and data (D) requesters. One word access at a time:
//   IDLE (arbitrate and latch) -> ACCESS (drive Memory) -> RESP (return word).
// Ports
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  mem_access_arbiter_if.slave: requester ports, Memory pins, busy
// Parameters
//   MEM_BYTES   size of the Memory byte array
//   STARVE_MAX  consecutive D grants allowed while IF waits before IF wins once
//
// state  | meaning
// S_IDLE | waiting for a request; arbitrates and latches the winner
// S_ACCESS | Memory strobes driven for the latched access; read word captured
// S_RESP | winner's done pulse with registered rdata and err
module mem_access_arbiter #(
  parameter int MEM_BYTES  = 50,
  parameter int STARVE_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_arbiter_if.slave  bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  // Highest byte address at which a whole word still fits in the Memory.
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          we_q;
  logic          id_d_q;
  logic [SW-1:0] starve_q;
  logic          grant_d;
  logic          grant_if;
  logic          addr_err;

  // Unsigned 32-bit compare, so addresses near 0xFFFFFFFF never wrap into range.
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q > LAST_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      id_d_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        addr_q  <= bus.d_addr;
        we_q    <= bus.d_we;
        wdata_q <= bus.d_wdata;
        id_d_q  <= 1'b1;
        // Count only D wins that left IF waiting; saturate at the limit.
        if (!bus.if_req)
          starve_q <= '0;
        else if (starve_q != STARVE_LIM)
          starve_q <= starve_q + SW'(1);
      end
      if (grant_if) begin
        addr_q   <= bus.if_addr;
        we_q     <= 1'b0;
        wdata_q  <= '0;
        id_d_q   <= 1'b0;
        starve_q <= '0;
      end
      if (state == S_ACCESS)
        rdata_q <= (we_q || addr_err) ? 32'h0 : bus.mem_rdata;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_d       = 1'b0;
    grant_if      = 1'b0;
    bus.if_done   = 1'b0;
    bus.if_rdata  = 32'h0;
    bus.if_err    = 1'b0;
    bus.d_done    = 1'b0;
    bus.d_rdata   = 32'h0;
    bus.d_err     = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = 32'h0;
    bus.busy      = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        // D has priority unless IF has already been passed over STARVE_MAX times.
        if (bus.d_req && !(bus.if_req && (starve_q == STARVE_LIM))) begin
          grant_d   = 1'b1;
          state_nxt = S_ACCESS;
        end else if (bus.if_req) begin
          grant_if  = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_nxt = S_RESP;
        if (!addr_err) begin
          bus.mem_addr  = addr_q;
          bus.mem_read  = ~we_q;
          bus.mem_write = we_q;
          bus.mem_wdata = wdata_q;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        if (id_d_q) begin
          bus.d_done  = 1'b1;
          bus.d_rdata = rdata_q;
          bus.d_err   = addr_err;
        end else begin
          bus.if_done  = 1'b1;
          bus.if_rdata = rdata_q;
          bus.if_err   = addr_err;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
